bch_calc_matrix_seq: RTL and testbench



---
 rtl/bch_calc_matrix_seq_pkg.sv | 23 ++
 rtl/bch_lfsr_slice.sv | 32 +++
 rtl/bch_calc_matrix_seq.sv | 130 +++++++++++++
 tb/tb_bch_calc_matrix_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bch_calc_matrix_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bch_calc_matrix_seq_pkg : shared types, helpers and generator polynomials
// Rev 1.0
// ----------------------------------------------------------------------------
package bch_calc_matrix_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Number of slices needed to cover the data word, i.e. ceil(k/s).
  function automatic int f_num_slices(input int k, input int s);
    return (k + s - 1) / s;
  endfunction

  // Generator polynomials of the codes currently in use (MSB = x^r).
  localparam logic [3:0]  c_poly_ham_7_4  = 4'b1011;        // x^3 + x + 1
  localparam logic [11:0] c_poly_ham_r11  = 12'h805;        // x^11 + x^2 + 1

endpackage
`default_nettype wire

// File: rtl/bch_lfsr_slice.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bch_lfsr_slice : combinational pSliceWidth-bit remainder update, MSB first
// Rev 1.0
// ----------------------------------------------------------------------------
module bch_lfsr_slice
  import bch_calc_matrix_seq_pkg::*;
#(
  parameter int                    pParityWidth = 11,
  parameter int                    pSliceWidth  = 4,
  parameter logic [pParityWidth:0] pGenPoly     = '0
) (
  input  logic [pParityWidth-1:0] i_rem,
  input  logic [pSliceWidth-1:0]  i_slice,
  output logic [pParityWidth-1:0] o_rem
);

  logic [pParityWidth-1:0] w_rem;
  logic                    w_fb;

  always_comb begin
    w_rem = i_rem;
    w_fb  = 1'b0;
    for (int b = pSliceWidth - 1; b >= 0; b--) begin
      w_fb  = i_slice[b] ^ w_rem[pParityWidth-1];
      w_rem = (w_rem << 1) ^ (w_fb ? pGenPoly[pParityWidth-1:0] : '0);
    end
    o_rem = w_rem;
  end

endmodule
`default_nettype wire

// File: rtl/bch_calc_matrix_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bch_calc_matrix_seq : multi-cycle sliced-LFSR parity / syndrome calculator
// Rev 1.0
// ----------------------------------------------------------------------------
module bch_calc_matrix_seq
  import bch_calc_matrix_seq_pkg::*;
#(
  parameter int                    pDataWidth   = 16,
  parameter int                    pParityWidth = 11,
  parameter int                    pCodeWidth   = 27,
  parameter bit                    pParityMode  = 1'b1,
  parameter int                    pSliceWidth  = 4,
  parameter logic [pParityWidth:0] pGenPoly     = '0,
  parameter int                    pInWidth     = pParityMode ? pDataWidth : pCodeWidth
) (
  input  logic                    clk,
  input  logic                    rst_x,
  input  logic                    i_enable,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [pInWidth-1:0]     i_in,
  output logic                    o_valid,
  output logic [pParityWidth-1:0] o_result
);

  localparam int N     = f_num_slices(pDataWidth, pSliceWidth);
  localparam int PADW  = N * pSliceWidth;
  localparam int CNTW  = (N > 1) ? $clog2(N) : 1;

  state_e                  state_q, state_d;
  logic [pParityWidth-1:0] rem_q, rem_d;
  logic [PADW-1:0]         shift_q, shift_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [pParityWidth-1:0] result_q, result_d;
  logic [pParityWidth-1:0] par_q;
  logic [pParityWidth-1:0] w_slice_rem;
  logic [pDataWidth-1:0]   w_data;

  // The data field sits at the top of i_in in both modes.
  assign w_data = i_in[pInWidth-1 -: pDataWidth];

  bch_lfsr_slice #(
    .pParityWidth (pParityWidth),
    .pSliceWidth  (pSliceWidth),
    .pGenPoly     (pGenPoly)
  ) u_slice (
    .i_rem   (rem_q),
    .i_slice (shift_q[PADW-1 -: pSliceWidth]),
    .o_rem   (w_slice_rem)
  );

  generate
    if (!pParityMode) begin : g_syndrome
      always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
          par_q <= '0;
        end else if (i_enable && state_q == ST_IDLE && i_valid) begin
          par_q <= i_in[pParityWidth-1:0];
        end
      end
    end else begin : g_parity
      assign par_q = '0;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    result_d = result_q;
    o_ready  = 1'b0;
    if (!i_enable) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Ready is held low while the asynchronous reset is asserted.
          o_ready = rst_x;
          if (i_valid) begin
            shift_d = PADW'(w_data);
            rem_d   = '0;
            cnt_d   = CNTW'(N - 1);
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          rem_d   = w_slice_rem;
          shift_d = shift_q << pSliceWidth;
          if (cnt_q == '0) begin
            result_d = w_slice_rem ^ par_q;
            valid_d  = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_calc_matrix_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bch_calc_matrix_seq : directed self-checking bench over several configs
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_bch_calc_matrix_seq;
  import bch_calc_matrix_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        en;
  logic [6:0]  vld;
  logic [15:0] din;
  logic [6:0]  ov;
  logic [6:0]  ordy;
  logic [10:0] ores [7];
  logic [2:0]  ra, rb, rc;
  logic [10:0] rd, re, rf, rg;

  int n_cmp = 0;
  int n_bad = 0;
  int vcount [7];
  int expv   [7];

  always #5 clk = ~clk;

  assign ores[0] = {8'd0, ra};
  assign ores[1] = {8'd0, rb};
  assign ores[2] = {8'd0, rc};
  assign ores[3] = rd;
  assign ores[4] = re;
  assign ores[5] = rf;
  assign ores[6] = rg;

  // Hamming(7,4): slice 1, slice 3, and syndrome mode
  bch_calc_matrix_seq #(.pDataWidth(4), .pParityWidth(3), .pCodeWidth(7), .pParityMode(1'b1),
    .pSliceWidth(1), .pGenPoly(c_poly_ham_7_4)) u_a (.clk(clk), .rst_x(rst_x), .i_enable(en),
    .i_valid(vld[0]), .o_ready(ordy[0]), .i_in(din[3:0]), .o_valid(ov[0]), .o_result(ra));
  bch_calc_matrix_seq #(.pDataWidth(4), .pParityWidth(3), .pCodeWidth(7), .pParityMode(1'b1),
    .pSliceWidth(3), .pGenPoly(c_poly_ham_7_4)) u_b (.clk(clk), .rst_x(rst_x), .i_enable(en),
    .i_valid(vld[1]), .o_ready(ordy[1]), .i_in(din[3:0]), .o_valid(ov[1]), .o_result(rb));
  bch_calc_matrix_seq #(.pDataWidth(4), .pParityWidth(3), .pCodeWidth(7), .pParityMode(1'b0),
    .pSliceWidth(1), .pGenPoly(c_poly_ham_7_4)) u_c (.clk(clk), .rst_x(rst_x), .i_enable(en),
    .i_valid(vld[2]), .o_ready(ordy[2]), .i_in(din[6:0]), .o_valid(ov[2]), .o_result(rc));
  // k=16, r=11 with slices 4, 16, 3, 1
  bch_calc_matrix_seq #(.pDataWidth(16), .pParityWidth(11), .pCodeWidth(27), .pParityMode(1'b1),
    .pSliceWidth(4), .pGenPoly(c_poly_ham_r11)) u_d (.clk(clk), .rst_x(rst_x), .i_enable(en),
    .i_valid(vld[3]), .o_ready(ordy[3]), .i_in(din), .o_valid(ov[3]), .o_result(rd));
  bch_calc_matrix_seq #(.pDataWidth(16), .pParityWidth(11), .pCodeWidth(27), .pParityMode(1'b1),
    .pSliceWidth(16), .pGenPoly(c_poly_ham_r11)) u_e (.clk(clk), .rst_x(rst_x), .i_enable(en),
    .i_valid(vld[4]), .o_ready(ordy[4]), .i_in(din), .o_valid(ov[4]), .o_result(re));
  bch_calc_matrix_seq #(.pDataWidth(16), .pParityWidth(11), .pCodeWidth(27), .pParityMode(1'b1),
    .pSliceWidth(3), .pGenPoly(c_poly_ham_r11)) u_f (.clk(clk), .rst_x(rst_x), .i_enable(en),
    .i_valid(vld[5]), .o_ready(ordy[5]), .i_in(din), .o_valid(ov[5]), .o_result(rf));
  bch_calc_matrix_seq #(.pDataWidth(16), .pParityWidth(11), .pCodeWidth(27), .pParityMode(1'b1),
    .pSliceWidth(1), .pGenPoly(c_poly_ham_r11)) u_g (.clk(clk), .rst_x(rst_x), .i_enable(en),
    .i_valid(vld[6]), .o_ready(ordy[6]), .i_in(din), .o_valid(ov[6]), .o_result(rg));

  always @(negedge clk) begin
    for (int i = 0; i < 7; i++) if (ov[i] === 1'b1) vcount[i]++;
  end

  // Long division of d(x)*x^11 by x^11 + x^2 + 1.
  function automatic logic [10:0] model16(input logic [15:0] d);
    logic [26:0] v;
    logic [26:0] g;
    v = {d, 11'd0};
    g = 27'(c_poly_ham_r11);
    for (int i = 26; i >= 11; i--) if (v[i]) v = v ^ (g << (i - 11));
    return v[10:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_word(input int idx, input logic [15:0] w, input logic [10:0] exp,
                          input int n, input string tag);
    int cnt;
    @(negedge clk);
    din      = w;
    vld[idx] = 1'b1;
    chk({tag, "_ready"}, 32'(ordy[idx]), 32'd1);
    @(posedge clk); #1;
    vld[idx] = 1'b0;
    cnt = 0;
    while (ov[idx] !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(n));
    chk({tag, "_result"}, 32'(ores[idx]), 32'(exp));
    expv[idx]++;
  endtask

  initial begin
    logic [15:0] words [8];
    int          nsl   [7];
    rst_x = 1'b0;
    en    = 1'b1;
    vld   = '0;
    din   = '0;
    for (int i = 0; i < 7; i++) begin vcount[i] = 0; expv[i] = 0; end
    nsl[3] = 4; nsl[4] = 1; nsl[5] = 6; nsl[6] = 16;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      chk("rst_ready", 32'(ordy[i]), 32'd0);
      chk("rst_valid", 32'(ov[i]), 32'd0);
      chk("rst_result", 32'(ores[i]), 32'd0);
    end
    rst_x = 1'b1;
    #1;
    chk("idle_ready_all", 32'(ordy), 32'h7f);

    // Hamming(7,4) parity, one bit per cycle
    run_word(0, 16'h0008, 11'h5, 4, "h74s1_1000");
    run_word(0, 16'h0001, 11'h3, 4, "h74s1_0001");
    // Three bits per cycle, padded to two slices
    run_word(1, 16'h0008, 11'h5, 2, "h74s3_1000");

    // Back-to-back: new word accepted in the strobe cycle, every 3 cycles
    @(negedge clk);
    din    = 16'h0008;
    vld[1] = 1'b1;
    @(posedge clk); #1;
    chk("b2b_busy_ready", 32'(ordy[1]), 32'd0);
    din = 16'h0001;
    @(posedge clk); #1;
    chk("b2b_no_early_valid", 32'(ov[1]), 32'd0);
    @(posedge clk); #1;
    chk("b2b_valid1", 32'(ov[1]), 32'd1);
    chk("b2b_result1", 32'(ores[1]), 32'h5);
    chk("b2b_ready_on_strobe", 32'(ordy[1]), 32'd1);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    chk("b2b_valid_pulse", 32'(ov[1]), 32'd0);
    chk("b2b_busy_ready2", 32'(ordy[1]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_valid2", 32'(ov[1]), 32'd1);
    chk("b2b_result2", 32'(ores[1]), 32'h3);
    expv[1] += 2;

    // Syndrome mode on {data, parity}
    run_word(2, 16'h0045, 11'h0, 4, "syn_1000101");
    run_word(2, 16'h0044, 11'h1, 4, "syn_1000100");
    run_word(2, 16'h0005, 11'h5, 4, "syn_0000101");

    // Abort with i_enable low in the second BUSY cycle; o_result stays 011
    @(negedge clk);
    din    = 16'h0008;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    #1;
    chk("abort_ready_low", 32'(ordy[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(ov[0]), 32'd0);
      chk("abort_result_hold", 32'(ores[0]), 32'h3);
    end
    chk("abort_ready_still_low", 32'(ordy[0]), 32'd0);
    en = 1'b1;
    #1;
    chk("abort_ready_back", 32'(ordy[0]), 32'd1);
    run_word(0, 16'h0008, 11'h5, 4, "h74s1_after_abort");

    // Asynchronous reset mid-BUSY
    run_word(3, 16'h8000, model16(16'h8000), 4, "k16s4_pre_rst");
    @(negedge clk);
    din    = 16'hBEEF;
    vld[3] = 1'b1;
    @(posedge clk); #1;
    vld[3] = 1'b0;
    @(posedge clk); #1;
    rst_x = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov[3]), 32'd0);
    chk("midrst_result", 32'(ores[3]), 32'd0);
    chk("midrst_ready", 32'(ordy[3]), 32'd0);
    @(negedge clk);
    rst_x = 1'b1;
    run_word(3, 16'hBEEF, model16(16'hBEEF), 4, "k16s4_post_rst");

    // k=16 regression across slice widths against long division
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF; words[3] = 16'hA5C3;
    words[4] = 16'h1234; words[5] = 16'($urandom); words[6] = 16'($urandom);
    words[7] = 16'($urandom);
    for (int idx = 3; idx < 7; idx++) begin
      for (int j = 0; j < 8; j++) begin
        run_word(idx, words[j], model16(words[j]), nsl[idx], "k16_regr");
      end
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) chk("valid_count", 32'(vcount[i]), 32'(expv[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
